// File: rtl/regfile_param_if.sv
// Register file access bundle: one write port, NUM_RD read ports and the
// decoded write strobe. master = requester, slave = register file.
interface regfile_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [WIDTH-1:0]           wdata;
    logic [NUM_RD-1:0]          re;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*WIDTH-1:0]    rdata;
    logic [NUM_RD-1:0]          rvalid;
    logic [DEPTH-1:0]           wsel;

    modport master (
        output we, waddr, wdata, re, raddr,
        input  rdata, rvalid, wsel
    );

    modport slave (
        input  we, waddr, wdata, re, raddr,
        output rdata, rvalid, wsel
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: tree-decoded write strobe, NUM_RD read ports,
// optional zero register, write bypass, 0/1-cycle read latency.
// Ports: clk, rst_n (async active-low), bus (regfile_param_if.slave).
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_LAT   = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int ODD   = ADDR_W % 2;
    localparam int NST   = (ADDR_W + 1) / 2;

    if (RD_LAT < 0 || RD_LAT > 1) begin : g_bad_lat
        $error("regfile_param: RD_LAT must be 0 or 1");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_rd
        $error("regfile_param: NUM_RD must be 1..4");
    end
    if (WIDTH < 1 || ADDR_W < 1) begin : g_bad_dim
        $error("regfile_param: WIDTH and ADDR_W must be >= 1");
    end

    // Decode tree, MSBs first. Root is 1-to-2 for odd ADDR_W, else 2-to-4;
    // every later stage is a 2-to-4 gated by its parent's enable.
    for (genvar s = 0; s < NST; s++) begin : g_st
        localparam int BI  = (s == 0 && ODD == 1) ? 1 : 2;
        localparam int BC  = (ODD == 1) ? 2 * s + 1 : 2 * s + 2;
        localparam int NIN = 1 << (BC - BI);

        logic [NIN-1:0]       w_par;
        logic [(1<<BC)-1:0]   w_en;
        logic [BI-1:0]        w_fld;

        if (s == 0) begin : g_root
            assign w_par = bus.we;
        end else begin : g_node
            assign w_par = g_st[s-1].w_en;
        end

        assign w_fld = bus.waddr[ADDR_W-BC +: BI];

        for (genvar j = 0; j < NIN; j++) begin : g_par
            for (genvar k = 0; k < (1 << BI); k++) begin : g_out
                assign w_en[j*(1<<BI)+k] = w_par[j] && (w_fld == BI'(k));
            end
        end
    end

    logic [DEPTH-1:0] w_dec;
    logic [DEPTH-1:0] w_wsel;

    assign w_dec    = g_st[NST-1].w_en;
    assign w_wsel   = {w_dec[DEPTH-1:1], w_dec[0] & (ZERO_REG == 0)};
    assign bus.wsel = w_wsel;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wsel[i]) begin
                    r_mem[i] <= bus.wdata;
                end
            end
        end
    end

    logic [ADDR_W-1:0] w_ra   [NUM_RD];
    logic [WIDTH-1:0]  w_rval [NUM_RD];

    // Zero register overrides bypass, so a write to r0 never leaks out.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra[p]   = bus.raddr[p*ADDR_W +: ADDR_W];
            w_rval[p] = r_mem[w_ra[p]];
            if (BYPASS != 0 && bus.we && bus.waddr == w_ra[p]) begin
                w_rval[p] = bus.wdata;
            end
            if (ZERO_REG != 0 && w_ra[p] == '0) begin
                w_rval[p] = '0;
            end
        end
    end

    if (RD_LAT == 1) begin : g_reg_rd
        logic [NUM_RD*WIDTH-1:0] r_rdata;
        logic [NUM_RD-1:0]       r_rvalid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata  <= '0;
                r_rvalid <= '0;
            end else begin
                r_rvalid <= bus.re;
                for (int p = 0; p < NUM_RD; p++) begin
                    if (bus.re[p]) begin
                        r_rdata[p*WIDTH +: WIDTH] <= w_rval[p];
                    end
                end
            end
        end

        assign bus.rdata  = r_rdata;
        assign bus.rvalid = r_rvalid;
    end else begin : g_comb_rd
        for (genvar p = 0; p < NUM_RD; p++) begin : g_port
            assign bus.rdata[p*WIDTH +: WIDTH] = w_rval[p];
        end
        assign bus.rvalid = bus.re;
    end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised register file for the CPU datapath; successor to the fixed 16-entry decoded-write register file.
- Write address decoded internally to a one-hot strobe vector (generalised 2^ADDR_W decode tree with enable).
- Adds:
  - NUM_RD independent read ports
  - optional hardwired-zero register 0
  - write-to-read bypass
  - selectable combinational or registered read latency

Parameters:
WIDTH, 32, data word width in bits (>=1)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
RD_LAT, 0, read latency in cycles, 0 or 1 only

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
re  input  NUM_RD  per-port read enable
raddr  input  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*WIDTH  packed read data, port p at [p*WIDTH +: WIDTH]
rvalid  output  NUM_RD  per-port read data valid
wsel  output  DEPTH  decoded one-hot write strobe (observability)

Behaviour:

Reset:
- rst_n low asynchronously clears all DEPTH registers to 0.
- Reset also clears rdata and rvalid to 0 when RD_LAT=1.
- wsel is combinational and tracks its inputs during reset.
- Reset asserted mid-write wins: the register stays 0.
- First write accepted on the first rising edge after rst_n deasserts.

Write decode:
- wsel[i] = we && (waddr == i). At most one bit set; all 0 when we=0.
- When ZERO_REG=1, wsel[0] is forced 0.
- Register i loads wdata on the rising edge where wsel[i]=1; otherwise it holds.

Read, RD_LAT=0:
- rdata port p is combinational: mem[raddr_p].
- rvalid[p] = re[p].
- rdata is driven regardless of re.

Read, RD_LAT=1:
- On each rising edge, rvalid[p] <= re[p].
- If re[p]=1, rdata port p <= the read value. If re[p]=0, rdata port p holds its previous value.
- Data is available in the cycle after the request.

Read value:
- If ZERO_REG=1 and raddr_p==0: 0.
- Else if BYPASS=1 and we and waddr==raddr_p: wdata (new value).
- Else: stored mem[raddr_p] (old value).

Bypass behaviour:
- With BYPASS=0 and RD_LAT=0, a same-cycle read of the written address returns the old value.
- With BYPASS=0 and RD_LAT=1, the captured value is also the old value.

Multiple ports:
- All ports are independent and may read the same address in the same cycle; each receives an identical value.
- No port conflicts and no stalls.

Width and structure rules:
- No arithmetic.
- Out-of-range parameters (RD_LAT>1, NUM_RD=0) fail elaboration.
- The decode must scale to any ADDR_W>=1. It is built hierarchically from 2-to-4 enable-gated stages, padding with a 1-to-2 stage when ADDR_W is odd.

Test Plan:
- Reset/decode: hold rst_n=0, we=1, waddr=5 -> wsel=0x0020, all reads 0. Release reset, write 0xDEADBEEF to r5 -> next cycle read r5 = 0xDEADBEEF, r4 = 0.
- Zero register (ZERO_REG=1): write 0x12345678 to r0 -> wsel=0x0000, read r0 = 0 on both ports. ZERO_REG=0 -> read r0 = 0x12345678.
- Bypass (RD_LAT=0): r3=0x11, same cycle we=1, waddr=3, wdata=0x22, raddr0=3 -> rdata0=0x22 with BYPASS=1, 0x11 with BYPASS=0; next cycle both configurations read 0x22.
- Registered read (RD_LAT=1): re0=1, raddr0=7 (r7=0xA5) at edge N -> rvalid0=1, rdata0=0xA5 after edge N. re0=0 at edge N+1 -> rvalid0=0, rdata0 holds 0xA5.
- Multi-port/width sweep (WIDTH=8, ADDR_W=5, NUM_RD=3): fill r1..r31 with value = address, then read three distinct and three identical addresses per cycle -> each port returns its address value.
- Async reset mid-operation: pulse rst_n low for half a cycle between edges while we=1 -> all registers and rvalid read 0 immediately, and the pending write is not committed.
